mex_queue_sched: RTL and testbench
==================================

# mex_queue_sched

Slot allocator and issue scheduler for the 8-entry M_EX queue between memory-stage operand gathering and EX. Tracks slot occupancy, grants one-hot queue slots to incoming instructions, and records each entry's required wake bits and relative age. Issues the oldest entry whose required wake bits are all set. Slot wake state is written by the M_EX latch-update logic; this block only reads it and owns the valid bits.

## Interface
Parameters:
- PTCID_W, 7, width of an instruction ptcid.
- QDEPTH, 8, number of queue slots. Fixed at 8 because every qslot vector is 8 bits; other values are unsupported.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  requester has an instruction to enqueue.
- alloc_ptcid  in  PTCID_W  ptcid of the enqueuing instruction.
- alloc_wake_req  in  4  wake bits the instruction must see before issue.
- alloc_ready  out  1  at least one slot is free.
- alloc_qslot  out  8  one-hot slot granted this cycle; 0 when no free slot.
- slot_wake  in  32  current wake bits per slot; slot i uses [4i+3:4i].
- issue_ready  in  1  EX accepts an entry this cycle.
- issue_valid  out  1  an eligible entry exists.
- issue_qslot  out  8  one-hot slot of the selected entry; 0 when issue_valid=0.
- issue_ptcid  out  PTCID_W  ptcid of the selected entry; 0 when issue_valid=0.
- flush  in  1  drops all entries.
- valid_vec  out  8  per-slot valid bits, driven into the queue latch.
- occupancy  out  4  number of valid slots, range 0–8.
- full  out  1  occupancy == 8.
- empty  out  1  occupancy == 0.
- watchdog_err  out  1  sticky stall error (see Configuration).

## Operation
Per-slot state:
- valid
- ptcid[PTCID_W]
- wake_req[4]
- 8×8 age matrix: age[i][j]=1 means slot i is older than slot j.

Allocation:
- The lowest-index free slot is granted.
- Allocation fires on alloc_valid & alloc_ready.
- At the edge, the granted slot k latches valid=1, alloc_ptcid and alloc_wake_req.
- Age update on allocation of slot k:
  - age[j][k]=1 for every currently valid j.
  - row k is cleared.

Eligibility and selection:
- Slot i is eligible when valid[i] & ((wake_req[i] & ~slot_wake[4i+3:4i]) == 0).
- A wake_req of 4'b0000 is eligible immediately.
- The selected slot is the eligible i for which no eligible j has age[j][i]=1. At most one slot satisfies this.
- issue_valid = any eligible.
- Issue fires on issue_valid & issue_ready. At the edge the selected slot's valid is cleared and its age row and column are cleared.

Simultaneous events and boundaries:
- Allocate and issue in the same cycle is allowed and always targets distinct slots. Occupancy is unchanged.
- A slot freed by issue is not reusable in the same cycle: alloc_ready and alloc_qslot depend only on registered state.
- When full, alloc_ready=0 and alloc_valid is ignored.
- When empty, issue_valid=0.
- flush clears all valid bits and the age matrix at the edge, overriding any alloc or issue fire in that cycle.
- rst has the same effect as flush and also clears all stored ptcid and wake_req fields and the watchdog state.

## Timing
- All outputs are combinational from registered state plus slot_wake. There is no input-to-output path from alloc_* or issue_ready.
- Reset values of all outputs:
  - alloc_ready=1, alloc_qslot=8'h01.
  - issue_valid=0, issue_qslot=0, issue_ptcid=0.
  - valid_vec=0, occupancy=0, full=0, empty=1.
  - watchdog_err=0.
- Latency: an entry allocated at edge N can issue in cycle N+1 at the earliest. It is visible in valid_vec from cycle N+1.
- issue_valid may drop without a fire only when flush or rst is asserted. Otherwise the selected entry stays eligible, because wake bits only set.

## Configuration
- MEXQ_WATCHDOG_EN defined:
  - An 8-bit saturating counter increments each cycle in which occupancy is nonzero and no issue fires.
  - The counter clears on an issue fire, on flush, and on rst.
  - When the counter reaches 255, watchdog_err sets and stays set until rst. flush does not clear watchdog_err.
- MEXQ_WATCHDOG_EN undefined: no counter is built and watchdog_err is tied to 0.

## Test plan
- Fill test: after rst, alloc ptcids 0x10–0x17 on 8 consecutive cycles with issue_ready=0.
  - alloc_qslot steps 01, 02, 04, … 80.
  - Then full=1, alloc_ready=0, occupancy=8.
  - A 9th alloc_valid leaves state unchanged.
- Oldest-first: alloc A (slot0, req 4'b0001), then B (slot1, req 0).
  - With slot_wake=0, issue selects slot1 / B.
  - Then set slot_wake[0]=1: issue selects slot0 / A.
  - Set slot_wake[0]=1 before any issue instead: A issues first.
- Age after reuse: alloc slots 0, 1, 2 (req 0); issue slot0; alloc C into slot0.
  - Issue order is slot1, slot2, slot0.
- Simultaneous alloc and issue with occupancy 8 and issue firing on slot3:
  - alloc_ready=0 that cycle.
  - The next cycle, alloc_qslot=8'h08.
- Flush: occupancy 5, assert flush together with alloc_valid and issue_ready.
  - Next cycle: valid_vec=0, empty=1, alloc_qslot=8'h01.
- Watchdog (macro defined): alloc one entry with req 4'b1111, slot_wake=0.
  - watchdog_err=1 after 255 stalled cycles.
  - It persists through flush and clears on rst.
  - With the macro undefined, watchdog_err stays 0.

Source files
------------

// File: rtl/mex_queue_sched_if.sv
// Handshake/bus bundle between the M_EX queue requester/EX side and mex_queue_sched.
interface mex_queue_sched_if #(
  parameter int PTCID_W = 7
);
  logic               alloc_valid;
  logic [PTCID_W-1:0] alloc_ptcid;
  logic [3:0]         alloc_wake_req;
  logic               alloc_ready;
  logic [7:0]         alloc_qslot;
  logic [31:0]        slot_wake;
  logic               issue_ready;
  logic               issue_valid;
  logic [7:0]         issue_qslot;
  logic [PTCID_W-1:0] issue_ptcid;
  logic               flush;
  logic [7:0]         valid_vec;
  logic [3:0]         occupancy;
  logic               full;
  logic               empty;
  logic               watchdog_err;

  modport master (
    output alloc_valid, alloc_ptcid, alloc_wake_req, slot_wake, issue_ready, flush,
    input  alloc_ready, alloc_qslot, issue_valid, issue_qslot, issue_ptcid,
           valid_vec, occupancy, full, empty, watchdog_err
  );

  modport slave (
    input  alloc_valid, alloc_ptcid, alloc_wake_req, slot_wake, issue_ready, flush,
    output alloc_ready, alloc_qslot, issue_valid, issue_qslot, issue_ptcid,
           valid_vec, occupancy, full, empty, watchdog_err
  );
endinterface

// File: rtl/mex_queue_sched.sv
// 8-entry M_EX queue slot allocator and oldest-ready issue scheduler.
// Optional stall watchdog built when MEXQ_WATCHDOG_EN is defined.
module mex_queue_sched #(
  parameter int PTCID_W = 7,
  parameter int QDEPTH  = 8
) (
  input logic          clk,
  input logic          rst,
  mex_queue_sched_if.slave q
);

  logic [QDEPTH-1:0]  valid_q;
  logic [PTCID_W-1:0] ptcid_q [QDEPTH];
  logic [3:0]         wreq_q  [QDEPTH];
  logic [QDEPTH-1:0]  age_q   [QDEPTH];
  logic [QDEPTH-1:0]  age_d   [QDEPTH];

  logic [QDEPTH-1:0]  free_vec;
  logic [QDEPTH-1:0]  alloc_oh;
  logic [QDEPTH-1:0]  elig;
  logic [QDEPTH-1:0]  sel;
  logic [QDEPTH-1:0]  col;
  logic [PTCID_W-1:0] sel_ptcid;
  logic [3:0]         occ;
  logic               alloc_fire;
  logic               issue_fire;

  assign free_vec   = ~valid_q;
  assign alloc_oh   = free_vec & (~free_vec + 8'd1);
  assign alloc_fire = q.alloc_valid & (|free_vec);
  assign issue_fire = (|elig) & q.issue_ready;

  always_comb begin
    elig      = '0;
    sel       = '0;
    col       = '0;
    sel_ptcid = '0;
    occ       = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      elig[i] = valid_q[i] & ((wreq_q[i] & ~q.slot_wake[4*i +: 4]) == 4'b0000);
      occ     = occ + {3'b000, valid_q[i]};
    end
    // An eligible slot wins only if no other eligible slot is older than it.
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      for (int unsigned j = 0; j < QDEPTH; j++) col[j] = age_q[j][i];
      sel[i] = elig[i] & ~(|(elig & col));
      if (sel[i]) sel_ptcid = sel_ptcid | ptcid_q[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      for (int unsigned j = 0; j < QDEPTH; j++) begin
        age_d[i][j] = age_q[i][j];
        if (issue_fire && (sel[i] || sel[j])) age_d[i][j] = 1'b0;
        // Survivors of this cycle's issue are older than the new entry.
        if (alloc_fire && alloc_oh[j]) age_d[i][j] = valid_q[i] & ~(issue_fire & sel[i]);
        if (alloc_fire && alloc_oh[i]) age_d[i][j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        ptcid_q[i] <= '0;
        wreq_q[i]  <= '0;
        age_q[i]   <= '0;
      end
    end else if (q.flush) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q <= (valid_q & ~(issue_fire ? sel : '0)) | (alloc_fire ? alloc_oh : '0);
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        age_q[i] <= age_d[i];
        if (alloc_fire && alloc_oh[i]) begin
          ptcid_q[i] <= q.alloc_ptcid;
          wreq_q[i]  <= q.alloc_wake_req;
        end
      end
    end
  end

  assign q.alloc_ready = |free_vec;
  assign q.alloc_qslot = alloc_oh;
  assign q.issue_valid = |elig;
  assign q.issue_qslot = sel;
  assign q.issue_ptcid = sel_ptcid;
  assign q.valid_vec   = valid_q;
  assign q.occupancy   = occ;
  assign q.full        = (occ == 4'd8);
  assign q.empty       = (occ == 4'd0);

`ifdef MEXQ_WATCHDOG_EN
  logic [7:0] wd_cnt_q;
  logic [7:0] wd_cnt_d;
  logic       wd_err_q;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (q.flush || issue_fire) wd_cnt_d = '0;
    else if ((occ != 4'd0) && (wd_cnt_q != 8'hFF)) wd_cnt_d = wd_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_cnt_d == 8'hFF) wd_err_q <= 1'b1;
    end
  end

  assign q.watchdog_err = wd_err_q;
`else
  assign q.watchdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_mex_queue_sched.sv
// Self-checking bench for mex_queue_sched: vector table, directed corner sequences,
// and randomized traffic against an age-ordered list reference model.
module tb_mex_queue_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mex_queue_sched_if #(.PTCID_W(7)) bus ();
  mex_queue_sched #(.PTCID_W(7), .QDEPTH(8)) dut (.clk(clk), .rst(rst), .q(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: slots plus an allocation-order list (oldest first).
  bit         m_v [8];
  logic [6:0] m_p [8];
  logic [3:0] m_w [8];
  int         m_order[$];
  int         m_cnt;
  bit         m_err;

  logic        cur_av, cur_ir, cur_fl, cur_rs;
  logic [6:0]  cur_p;
  logic [3:0]  cur_w;
  logic [31:0] cur_wk;

  function automatic int m_free();
    for (int i = 0; i < 8; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  function automatic int m_sel(input logic [31:0] wk);
    for (int k = 0; k < m_order.size(); k++) begin
      int s = m_order[k];
      if ((m_w[s] & ~wk[4*s +: 4]) == 4'b0000) return s;
    end
    return -1;
  endfunction

  task automatic drive(input logic av, input logic [6:0] p, input logic [3:0] wr,
                       input logic [31:0] wk, input logic ir, input logic fl, input logic rs);
    int f, s;
    logic [7:0] vv;
    bus.alloc_valid = av; bus.alloc_ptcid = p; bus.alloc_wake_req = wr;
    bus.slot_wake = wk; bus.issue_ready = ir; bus.flush = fl; rst = rs;
    cur_av = av; cur_p = p; cur_w = wr; cur_wk = wk; cur_ir = ir; cur_fl = fl; cur_rs = rs;
    #1;
    f = m_free();
    s = m_sel(wk);
    vv = '0;
    for (int i = 0; i < 8; i++) vv[i] = m_v[i];
    chk("m_alloc_ready", 32'(bus.alloc_ready), 32'(f >= 0));
    chk("m_alloc_qslot", 32'(bus.alloc_qslot), (f >= 0) ? (32'd1 << f) : 32'd0);
    chk("m_issue_valid", 32'(bus.issue_valid), 32'(s >= 0));
    chk("m_issue_qslot", 32'(bus.issue_qslot), (s >= 0) ? (32'd1 << s) : 32'd0);
    chk("m_issue_ptcid", 32'(bus.issue_ptcid), (s >= 0) ? 32'(m_p[s]) : 32'd0);
    chk("m_valid_vec",   32'(bus.valid_vec), 32'(vv));
    chk("m_occupancy",   32'(bus.occupancy), 32'(m_order.size()));
    chk("m_full",        32'(bus.full), 32'(m_order.size() == 8));
    chk("m_empty",       32'(bus.empty), 32'(m_order.size() == 0));
    chk("m_watchdog",    32'(bus.watchdog_err), 32'(m_err));
  endtask

  task automatic tick();
    int f, s, occ;
    bit fi, fa;
    @(posedge clk);
    f = m_free();
    s = m_sel(cur_wk);
    occ = m_order.size();
    if (cur_rs) begin
      for (int i = 0; i < 8; i++) begin m_v[i] = 0; m_p[i] = '0; m_w[i] = '0; end
      m_order.delete();
      m_cnt = 0; m_err = 0;
    end else if (cur_fl) begin
      for (int i = 0; i < 8; i++) m_v[i] = 0;
      m_order.delete();
      m_cnt = 0;
    end else begin
      fi = (s >= 0) && cur_ir;
      fa = cur_av && (f >= 0);
      if (fi) begin
        m_v[s] = 0;
        for (int k = 0; k < m_order.size(); k++)
          if (m_order[k] == s) begin m_order.delete(k); break; end
      end
      if (fa) begin
        m_v[f] = 1; m_p[f] = cur_p; m_w[f] = cur_w;
        m_order.push_back(f);
      end
`ifdef MEXQ_WATCHDOG_EN
      if (fi) m_cnt = 0;
      else if (occ != 0 && m_cnt < 255) m_cnt++;
      if (m_cnt == 255) m_err = 1;
`endif
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] wk, input logic ir);
    drive(1'b0, 7'h0, 4'h0, wk, ir, 1'b0, 1'b0);
  endtask

  task automatic alloc(input logic [6:0] p, input logic [3:0] wr, input logic [31:0] wk);
    drive(1'b1, p, wr, wk, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 7'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  typedef struct {
    logic       av;
    logic [6:0] p;
    logic [7:0] e_aq;
    logic [7:0] e_iq;
    logic [3:0] e_occ;
  } vec_t;

  vec_t tbl [10];
  logic [31:0] wk;
  logic [3:0]  wr;

  initial begin
    bus.alloc_valid = 0; bus.alloc_ptcid = '0; bus.alloc_wake_req = '0;
    bus.slot_wake = '0; bus.issue_ready = 0; bus.flush = 0; rst = 1;
    m_cnt = 0; m_err = 0;
    for (int i = 0; i < 8; i++) begin m_v[i] = 0; m_p[i] = '0; m_w[i] = '0; end
    @(negedge clk);
    do_reset();

    // Reset state
    idle(32'h0, 1'b0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_alloc_qslot", 32'(bus.alloc_qslot), 32'h01);
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_issue_ptcid", 32'(bus.issue_ptcid), 32'd0);
    chk("rst_empty",       32'(bus.empty), 32'd1);
    chk("rst_watchdog",    32'(bus.watchdog_err), 32'd0);
    tick();

    // Fill test as a vector table
    for (int i = 0; i < 8; i++)
      tbl[i] = '{av: 1'b1, p: 7'(8'h10 + i), e_aq: 8'h01 << i,
                 e_iq: (i == 0) ? 8'h00 : 8'h01, e_occ: 4'(i)};
    tbl[8] = '{av: 1'b1, p: 7'h7F, e_aq: 8'h00, e_iq: 8'h01, e_occ: 4'd8};
    tbl[9] = '{av: 1'b0, p: 7'h00, e_aq: 8'h00, e_iq: 8'h01, e_occ: 4'd8};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].av, tbl[i].p, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_alloc_qslot", i), 32'(bus.alloc_qslot), 32'(tbl[i].e_aq));
      chk($sformatf("tbl%0d_issue_qslot", i), 32'(bus.issue_qslot), 32'(tbl[i].e_iq));
      chk($sformatf("tbl%0d_occupancy", i), 32'(bus.occupancy), 32'(tbl[i].e_occ));
      tick();
    end
    idle(32'h0, 1'b0);
    chk("fill_full",        32'(bus.full), 32'd1);
    chk("fill_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    chk("fill_issue_ptcid", 32'(bus.issue_ptcid), 32'h10);
    chk("fill_valid_vec",   32'(bus.valid_vec), 32'hFF);
    tick();

    // Oldest-first with wake gating
    do_reset();
    alloc(7'h0A, 4'b0001, 32'h0);
    alloc(7'h0B, 4'b0000, 32'h0);
    idle(32'h0, 1'b1);
    chk("of_sel_b", 32'(bus.issue_qslot), 32'h02);
    chk("of_ptcid_b", 32'(bus.issue_ptcid), 32'h0B);
    tick();
    idle(32'h1, 1'b1);
    chk("of_sel_a", 32'(bus.issue_qslot), 32'h01);
    chk("of_ptcid_a", 32'(bus.issue_ptcid), 32'h0A);
    tick();
    do_reset();
    alloc(7'h0A, 4'b0001, 32'h0);
    alloc(7'h0B, 4'b0000, 32'h0);
    idle(32'h1, 1'b1);
    chk("of_woken_a_first", 32'(bus.issue_qslot), 32'h01);
    tick();

    // Age after slot reuse
    do_reset();
    alloc(7'h01, 4'h0, 32'h0);
    alloc(7'h02, 4'h0, 32'h0);
    alloc(7'h03, 4'h0, 32'h0);
    idle(32'h0, 1'b1);
    chk("reuse_first", 32'(bus.issue_qslot), 32'h01);
    tick();
    drive(1'b1, 7'h0C, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reuse_grant", 32'(bus.alloc_qslot), 32'h01);
    tick();
    idle(32'h0, 1'b1);
    chk("reuse_ord1", 32'(bus.issue_qslot), 32'h02);
    tick();
    idle(32'h0, 1'b1);
    chk("reuse_ord2", 32'(bus.issue_qslot), 32'h04);
    tick();
    idle(32'h0, 1'b1);
    chk("reuse_ord3", 32'(bus.issue_qslot), 32'h01);
    chk("reuse_ptcid_c", 32'(bus.issue_ptcid), 32'h0C);
    tick();

    // Full queue: alloc + issue of slot3 in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) alloc(7'(8'h20 + i), (i == 3) ? 4'h0 : 4'hF, 32'h0);
    drive(1'b1, 7'h33, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    chk("full_issue_slot3", 32'(bus.issue_qslot), 32'h08);
    tick();
    idle(32'h0, 1'b0);
    chk("full_next_qslot", 32'(bus.alloc_qslot), 32'h08);
    chk("full_occ7", 32'(bus.occupancy), 32'd7);
    tick();

    // Flush overrides simultaneous alloc and issue
    do_reset();
    for (int i = 0; i < 5; i++) alloc(7'(i), 4'h0, 32'h0);
    drive(1'b1, 7'h44, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    idle(32'h0, 1'b0);
    chk("flush_valid_vec", 32'(bus.valid_vec), 32'h0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_qslot", 32'(bus.alloc_qslot), 32'h01);
    tick();

    // Watchdog
    do_reset();
    alloc(7'h55, 4'hF, 32'h0);
`ifdef MEXQ_WATCHDOG_EN
    for (int k = 1; k <= 256; k++) begin
      idle(32'h0, 1'b0);
      if (k == 255) chk("wd_not_yet", 32'(bus.watchdog_err), 32'd0);
      if (k == 256) chk("wd_set", 32'(bus.watchdog_err), 32'd1);
      tick();
    end
    drive(1'b0, 7'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    idle(32'h0, 1'b0);
    chk("wd_after_flush", 32'(bus.watchdog_err), 32'd1);
    tick();
    do_reset();
    idle(32'h0, 1'b0);
    chk("wd_after_rst", 32'(bus.watchdog_err), 32'd0);
    tick();
`else
    for (int k = 0; k < 300; k++) begin idle(32'h0, 1'b0); tick(); end
    idle(32'h0, 1'b0);
    chk("wd_disabled", 32'(bus.watchdog_err), 32'd0);
    tick();
`endif

    // Randomized traffic against the model
    do_reset();
    wk = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) wk = wk | ($urandom & $urandom);
      if ($urandom_range(0, 39) == 0) wk = '0;
      wr = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      drive($urandom_range(0, 99) < 60, 7'($urandom), wr, wk,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) == 0,
            $urandom_range(0, 299) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
